// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - wide adder that reuses one narrow ripple adder over several cycles

module ripple_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = c_i;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = carry[WIDTH];

endmodule

module seq_chunk_adder #(
   parameter int CHUNK_WIDTH = 8,
   parameter int NUM_CHUNKS  = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] A,
   input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] B,
   input  logic                              C_in,
   output logic                              busy,
   output logic                              done,
   output logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] S,
   output logic                              C_out
);

   localparam int W     = CHUNK_WIDTH * NUM_CHUNKS;
   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     s_q, s_d;
   logic             cout_q, cout_d;

   logic [CHUNK_WIDTH-1:0] chunk_s;
   logic                   chunk_c;
   logic [W-1:0]           acc_shift;
   logic                   last_chunk;

   ripple_adder #(.WIDTH(CHUNK_WIDTH)) u_ripple_adder (
      .a_i (a_q[CHUNK_WIDTH-1:0]),
      .b_i (b_q[CHUNK_WIDTH-1:0]),
      .c_i (carry_q),
      .s_o (chunk_s),
      .c_o (chunk_c)
   );

   // Chunk sums enter at the top; after NUM_CHUNKS shifts chunk 0 sits at bit 0.
   assign acc_shift  = W'({chunk_s, acc_q} >> CHUNK_WIDTH);
   assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cout_d  = cout_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = A;
               b_d     = B;
               carry_d = C_in;
               cnt_d   = '0;
               acc_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> CHUNK_WIDTH;
            b_d     = b_q >> CHUNK_WIDTH;
            carry_d = chunk_c;
            acc_d   = acc_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_chunk) begin
               state_d = ST_DONE;
               s_d     = acc_shift;
               cout_d  = chunk_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   assign S     = s_q;
   assign C_out = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed and random checks of seq_chunk_adder at default parameters

module tb_seq_chunk_adder;

   localparam int CW = 8;
   localparam int NC = 5;
   localparam int W  = CW * NC;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A, B, S;
   logic         C_in, busy, done, C_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_chunk_adder #(.CHUNK_WIDTH(CW), .NUM_CHUNKS(NC)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .C_in  (C_in),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .C_out (C_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      A     = a;
      B     = b;
      C_in  = cin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = ~a;
      B     = ~b;
      C_in  = ~cin;
   endtask

   task automatic wait_done(output int nb);
      logic [W:0] r0;
      int         guard;
      r0    = {C_out, S};
      nb    = 0;
      guard = 0;
      while (!done && guard < 20) begin
         if (busy) nb++;
         guard++;
         @(negedge clk);
         if (!done) chk("result_stable_while_busy", {23'd0, C_out, S}, {23'd0, r0});
      end
      chk("done_seen", done, 1);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic [W:0] exp);
      int nb;
      start_op(a, b, cin);
      wait_done(nb);
      chk("busy_cycles", nb, NC);
      chk("sum", {23'd0, C_out, S}, {23'd0, exp});
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rc;
      int          nb;
      int          gap;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      C_in  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_S", S, 0);
      chk("reset_C_out", C_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      rst = 1'b0;
      A   = 40'hAA_5555_AAAA;
      B   = 40'h12_3456_789A;
      repeat (3) begin
         @(negedge clk);
         chk("idle_outputs", {busy, done, C_out, S}, 0);
      end

      op(40'hFF_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 41'h100_0000_0000);
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      op(40'h00_0000_0000, 40'h00_0000_0000, 1'b1, 41'h000_0000_0001);
      @(negedge clk);
      op(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 41'h1FF_FFFF_FFFF);
      @(negedge clk);

      // start pulsed on the 2nd busy cycle must be ignored
      start_op(40'h12_3456_789A, 40'h01_1111_1111, 1'b0);
      @(negedge clk);
      A     = 40'hFF_FFFF_FFFF;
      B     = 40'hFF_FFFF_FFFF;
      C_in  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb);
      chk("ignored_start_busy_left", nb, 3);
      chk("ignored_start_sum", {23'd0, C_out, S}, 64'h013_4567_89AB);
      @(negedge clk);
      chk("ignored_start_not_queued_busy", busy, 0);
      chk("ignored_start_not_queued_done", done, 0);

      // back-to-back: start during the DONE cycle
      op(40'h00_0000_0003, 40'h00_0000_0004, 1'b0, 41'd7);
      start_op(40'd5, 40'd7, 1'b0);
      chk("b2b_busy_next", busy, 1);
      wait_done(nb);
      chk("b2b_busy_cycles", nb, NC);
      chk("b2b_sum", {23'd0, C_out, S}, 64'd12);

      // reset on the 3rd busy cycle abandons the operation
      start_op(40'd1, 40'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_busy", busy, 0);
      chk("midreset_S", {23'd0, C_out, S}, 0);
      repeat (6) begin
         @(negedge clk);
         chk("midreset_no_done", done, 0);
      end

      for (int i = 0; i < 30; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         op(ra[W-1:0], rb[W-1:0], rc,
            {1'b0, ra[W-1:0]} + {1'b0, rb[W-1:0]} + {{W{1'b0}}, rc});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Multi-cycle wide adder controller that time-shares one narrow `ripple_adder` instance of `CHUNK_WIDTH` bits over `NUM_CHUNKS` cycles. It forms the full `CHUNK_WIDTH*NUM_CHUNKS`-bit sum with a registered inter-chunk carry. The block trades latency for area and carry-chain length, and sits between the operand source (switches/registers on Basys2) and the result display or consumer logic. A start/busy/done handshake sequences it.

## Interface
- `CHUNK_WIDTH`, default 8: width of the shared `ripple_adder` instance.
- `NUM_CHUNKS`, default 5: number of chunks. Total width W = `CHUNK_WIDTH*NUM_CHUNKS` (default 40).
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new addition. Sampled only when the block is not busy.
- `A`, input, W: operand A. Captured on an accepted start.
- `B`, input, W: operand B. Captured on an accepted start.
- `C_in`, input, 1: carry into bit 0. Captured on an accepted start.
- `busy`, output, 1: high while chunks are being computed.
- `done`, output, 1: one-cycle pulse when `S`/`C_out` take the new result.
- `S`, output, W: registered sum of the last completed operation.
- `C_out`, output, 1: registered carry out of bit W-1 of the last completed operation.

## Operation
- FSM with 3 states:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→RUN while the chunk counter is less than `NUM_CHUNKS-1`.
  - RUN→DONE on the cycle that processes chunk `NUM_CHUNKS-1`.
  - DONE→RUN if `start`=1.
  - DONE→IDLE otherwise.
- Accept (start in IDLE or DONE):
  - Load A and B into operand shift registers.
  - Load the carry register with `C_in`.
  - Clear the chunk counter (width `$clog2(NUM_CHUNKS)`, minimum 1) to 0.
  - Clear the accumulation register.
- Each RUN cycle:
  - The shared `ripple_adder` adds the low `CHUNK_WIDTH` bits of both operand registers plus the carry register.
  - The chunk sum is shifted into the top of the accumulation register, which shifts right by `CHUNK_WIDTH`.
  - Both operand registers shift right by `CHUNK_WIDTH`.
  - The carry register takes the chunk's `C_out`.
  - The counter increments.
- On the RUN→DONE edge:
  - `S` loads the completed accumulation value, including the final chunk.
  - `C_out` loads the final chunk carry.
- `S` and `C_out` change only on that edge. They are stable during RUN and hold their value until the next completion.
- `start` while in RUN is ignored. It is not queued, and the operands are not resampled.
- Arithmetic: result is exactly {`C_out`,`S`} = A + B + `C_in` modulo 2^(W+1). No saturation.
- `NUM_CHUNKS`=1 is legal: RUN lasts one cycle.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0.
  - `S`=0, `C_out`=0.
  - Counter, carry, operand and accumulation registers = 0.
- Reset has priority over all other inputs, including a start in the same cycle.
- Reset asserted mid-RUN abandons the operation. No `done` is produced, and `S`/`C_out` are cleared to 0.
- Latency, with `start` sampled at edge E:
  - `busy`=1 in the cycles following edges E … E+`NUM_CHUNKS`-1.
  - `S`/`C_out` are updated at edge E+`NUM_CHUNKS`.
  - `done`=1 for exactly the one cycle after that edge. With default parameters this is 5 edges after acceptance.
- Back-to-back: `start`=1 during the DONE cycle is accepted. `busy` rises in the next cycle, with no IDLE gap, so throughput is one result per `NUM_CHUNKS`+1 cycles.
- Operands may change freely after the accepting edge.

## Test plan
- Reset then idle: after `rst`=1 for 2 cycles → `S`=0, `C_out`=0, `busy`=0, `done`=0; with `start` held 0 all outputs remain constant.
- Full carry ripple across all chunks: A=0xFF_FFFF_FFFF, B=0x00_0000_0001, C_in=0 → exactly 5 `busy` cycles, then `done` pulse, `S`=0x00_0000_0000, `C_out`=1.
- Carry-in only: A=0, B=0, C_in=1 → `S`=0x00_0000_0001, `C_out`=0; A=0xFF_FFFF_FFFF, B=0xFF_FFFF_FFFF, C_in=1 → `S`=0xFF_FFFF_FFFF, `C_out`=1.
- Start during RUN ignored: start A=0x12_3456_789A, B=0x01_1111_1111; pulse `start` with different operands on the 2nd busy cycle → a single `done`, with `S`=0x13_4567_89AB, `C_out`=0; `S` unchanged during busy.
- Back-to-back and reset mid-op:
  - Assert `start` in the DONE cycle with A=5, B=7 → `busy` the next cycle, then `S`=12.
  - Then start A=1, B=1 and assert `rst` on the 3rd busy cycle → no `done` is produced, and `S`=0 after reset.
- Randomized: 1000 random A/B/C_in with random back-to-back gaps at default and at `CHUNK_WIDTH`=4, `NUM_CHUNKS`=1 → {`C_out`,`S`} matches the reference sum, and `done` arrives exactly `NUM_CHUNKS` edges after acceptance.
